// File: rtl/tdm_demux.sv
// Receive-side 4-slot TDM demultiplexer: locks on frame_sync, steers beats to out0..out3.
// Optional build macro TDM_DEMUX_STRICT_SYNC_EN: a slot-0 beat without frame_sync drops lock.
module tdm_demux #(
  parameter int DATA_W = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              frame_sync,
  output logic [DATA_W-1:0] out0,
  output logic [DATA_W-1:0] out1,
  output logic [DATA_W-1:0] out2,
  output logic [DATA_W-1:0] out3,
  output logic [3:0]        out_strobe,
  output logic [1:0]        slot,
  output logic              locked,
  output logic              frame_done,
  output logic              sync_err
);

`ifdef TDM_DEMUX_STRICT_SYNC_EN
  localparam bit STRICT_SYNC = 1'b1;
`else
  localparam bit STRICT_SYNC = 1'b0;
`endif

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e                   state_q, state_d;
  logic [1:0]               slot_q, slot_d;
  logic [3:0][DATA_W-1:0]   out_q, out_d;
  logic [3:0]               strobe_q, strobe_d;
  logic                     frame_done_q, frame_done_d;
  logic                     sync_err_q, sync_err_d;

  // Next-state: slot steering, lock tracking and the one-cycle status pulses.
  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    out_d        = out_q;
    strobe_d     = 4'b0000;
    frame_done_d = 1'b0;
    sync_err_d   = 1'b0;
    if (in_valid) begin
      case (state_q)
        HUNT: begin
          if (frame_sync) begin
            out_d[0] = in_data;
            strobe_d = 4'b0001;
            slot_d   = 2'd1;
            state_d  = LOCKED;
          end else begin
            state_d  = HUNT;
          end
        end
        LOCKED: begin
          if (frame_sync && (slot_q != 2'd0)) begin
            // Early sync: restart the frame at slot 0, truncated frame is not reported done.
            sync_err_d = 1'b1;
            out_d[0]   = in_data;
            strobe_d   = 4'b0001;
            slot_d     = 2'd1;
          end else if (STRICT_SYNC && !frame_sync && (slot_q == 2'd0)) begin
            sync_err_d = 1'b1;
            slot_d     = 2'd0;
            state_d    = HUNT;
          end else begin
            out_d[slot_q] = in_data;
            strobe_d      = 4'b0001 << slot_q;
            frame_done_d  = (slot_q == 2'd3);
            slot_d        = slot_q + 2'd1;
          end
        end
        default: begin
          state_d = HUNT;
          slot_d  = 2'd0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= HUNT;
      slot_q       <= 2'd0;
      out_q        <= '0;
      strobe_q     <= 4'b0000;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      out_q        <= out_d;
      strobe_q     <= strobe_d;
      frame_done_q <= frame_done_d;
      sync_err_q   <= sync_err_d;
    end
  end

  assign out0       = out_q[0];
  assign out1       = out_q[1];
  assign out2       = out_q[2];
  assign out3       = out_q[3];
  assign out_strobe = strobe_q;
  assign slot       = slot_q;
  assign locked     = (state_q == LOCKED);
  assign frame_done = frame_done_q;
  assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Self-checking bench for tdm_demux: directed scenarios plus randomized beats against a frame model.
module tb_tdm_demux;
  localparam int DW = 8;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          frame_sync;
  logic [DW-1:0] out0, out1, out2, out3;
  logic [3:0]    out_strobe;
  logic [1:0]    slot;
  logic          locked, frame_done, sync_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int            m_locked;
  int            m_slot;
  int            m_out [4];
  int            m_strobe;
  int            m_fd;
  int            m_err;

  tdm_demux #(.DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .frame_sync(frame_sync), .out0(out0), .out1(out1), .out2(out2), .out3(out3),
    .out_strobe(out_strobe), .slot(slot), .locked(locked),
    .frame_done(frame_done), .sync_err(sync_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_slot = 0; m_strobe = 0; m_fd = 0; m_err = 0;
    for (int i = 0; i < 4; i++) m_out[i] = 0;
  endtask

  // Frame rules: lock on sync, slots advance per beat, early sync restarts the frame.
  task automatic model_beat(input bit v, input bit s, input int d);
    m_strobe = 0; m_fd = 0; m_err = 0;
    if (v) begin
      if (m_locked == 0) begin
        if (s) begin
          m_out[0] = d; m_strobe = 1; m_slot = 1; m_locked = 1;
        end
      end else if (s && m_slot != 0) begin
        m_err = 1; m_out[0] = d; m_strobe = 1; m_slot = 1;
`ifdef TDM_DEMUX_STRICT_SYNC_EN
      end else if (!s && m_slot == 0) begin
        m_err = 1; m_locked = 0; m_slot = 0;
`endif
      end else begin
        m_out[m_slot] = d;
        m_strobe = 2 ** m_slot;
        m_fd = (m_slot == 3) ? 1 : 0;
        m_slot = (m_slot + 1) % 4;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".out0"}, 32'(out0), m_out[0]);
    check({tag, ".out1"}, 32'(out1), m_out[1]);
    check({tag, ".out2"}, 32'(out2), m_out[2]);
    check({tag, ".out3"}, 32'(out3), m_out[3]);
    check({tag, ".strobe"}, 32'(out_strobe), m_strobe);
    check({tag, ".slot"}, 32'(slot), m_slot);
    check({tag, ".locked"}, 32'(locked), m_locked);
    check({tag, ".fdone"}, 32'(frame_done), m_fd);
    check({tag, ".serr"}, 32'(sync_err), m_err);
  endtask

  task automatic drive(input string tag, input bit v, input bit s, input int d);
    in_valid = v; frame_sync = s; in_data = DW'(d);
    @(posedge clk); #1;
    model_beat(v, s, d);
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    rst_n = 1'b0;
    #2;
    model_reset();
    check_all(tag);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] tp1_stb [4];
    int         tp1_dat [4];
    tp1_stb = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    tp1_dat = '{1, 0, 0, 1};
    in_valid = 1'b0; frame_sync = 1'b0; in_data = '0;
    rst_n = 1'b0;
    #3;
    model_reset();
    check_all("reset");
    rst_n = 1'b1;

    // Basic frame A..D, sync only on A
    for (int i = 0; i < 4; i++) begin
      drive("tp1", 1'b1, (i == 0), tp1_dat[i]);
      check("tp1_strobe", 32'(out_strobe), 32'(tp1_stb[i]));
    end
    check("tp1_outs", {28'd0, out3[0], out2[0], out1[0], out0[0]}, 32'h9);
    check("tp1_fdone", 32'(frame_done), 32'd1);
    check("tp1_slot", 32'(slot), 32'd0);

    // Hunt: beats without sync are dropped
    async_reset("tp2_rst");
    for (int i = 0; i < 3; i++) drive("tp2_hunt", 1'b1, 1'b0, 8'h11 + i);
    check("tp2_unlocked", 32'(locked), 32'd0);
    drive("tp2_lock", 1'b1, 1'b1, 8'h7E);
    check("tp2_locked", 32'(locked), 32'd1);
    check("tp2_out0", 32'(out0), 32'h7E);

    // Early sync at slot 2
    drive("tp3_b1", 1'b1, 1'b0, 8'h22);
    check("tp3_slot2", 32'(slot), 32'd2);
    drive("tp3_resync", 1'b1, 1'b1, 8'hAB);
    check("tp3_serr", 32'(sync_err), 32'd1);
    check("tp3_out0", 32'(out0), 32'hAB);
    check("tp3_slot", 32'(slot), 32'd1);
    check("tp3_fdone", 32'(frame_done), 32'd0);

    // Idle gap mid-frame at slot 1
    for (int i = 0; i < 5; i++) drive("tp4_idle", 1'b0, (i == 2), 8'hEE);
    drive("tp4_resume", 1'b1, 1'b0, 8'h5C);
    check("tp4_out1", 32'(out1), 32'h5C);

    // Asynchronous reset at slot 2, then non-sync beat is ignored
    check("tp5_slot2", 32'(slot), 32'd2);
    async_reset("tp5_rst");
    drive("tp5_nosync", 1'b1, 1'b0, 8'h33);
    check("tp5_unlocked", 32'(locked), 32'd0);

    // Slot-0 beat without sync while locked
    drive("tp6_lock", 1'b1, 1'b1, 8'h01);
    for (int i = 0; i < 3; i++) drive("tp6_fill", 1'b1, 1'b0, 8'h02 + i);
    drive("tp6_s0", 1'b1, 1'b0, 8'hC4);
`ifdef TDM_DEMUX_STRICT_SYNC_EN
    check("tp6_serr", 32'(sync_err), 32'd1);
    check("tp6_out0", 32'(out0), 32'h01);
    check("tp6_locked", 32'(locked), 32'd0);
`else
    check("tp6_serr", 32'(sync_err), 32'd0);
    check("tp6_out0", 32'(out0), 32'hC4);
    check("tp6_locked", 32'(locked), 32'd1);
`endif

    // Randomized traffic with occasional mid-stream reset
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        @(negedge clk);
        async_reset("rnd_rst");
      end
      drive("rnd", ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 2),
            int'($urandom_range(0, 255)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/tdm_demux.md
# tdm_demux

Time-division demultiplexer: the receive-side counterpart of the 4:1 `sel`-driven multiplexer.
- A single `DATA_W`-bit stream carries four channels in fixed slot order 0,1,2,3.
- The block locks to a frame marker, counts slots on every valid beat and steers each beat into one of four held output registers, one per channel.
- It sits between the shared serial link and the four per-channel consumers, and reports lock status and sync errors.

## Interface
Parameters
- `DATA_W`, default 1: width of one channel sample.

Ports
- `clk`  in  1  sole clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  the beat on `in_data` is present this cycle.
- `in_data`  in  `DATA_W`  sample for the current slot.
- `frame_sync`  in  1  qualified by `in_valid`; marks this beat as slot 0.
- `out0`, `out1`, `out2`, `out3`  out  `DATA_W` each  held channel samples.
- `out_strobe`  out  4  one-cycle pulse; bit n is set when `outn` was just updated.
- `slot`  out  2  slot index the next valid beat is assigned to.
- `locked`  out  1  high in state LOCKED.
- `frame_done`  out  1  one-cycle pulse after a slot-3 beat is captured while locked.
- `sync_err`  out  1  one-cycle pulse when a misaligned or missing sync is detected.

## Operation
- Reset values: all outputs are 0. State is HUNT and the slot counter is 0.
- States: HUNT and LOCKED.
- In HUNT:
  - Beats with `in_valid` and `frame_sync` low are discarded. Outputs, strobes and `slot` do not change.
  - A beat with `in_valid` and `frame_sync` high is written to `out0`. `out_strobe` is 0001, `slot` becomes 1, and the state moves to LOCKED.
- In LOCKED, each beat with `in_valid` high:
  - Writes to the output selected by `slot` and raises the matching `out_strobe` bit.
  - Increments `slot` modulo 4, so 3 wraps to 0.
- A slot-3 capture in LOCKED also pulses `frame_done`.
- Resync: `frame_sync` arrives with a valid beat while `slot` is not 0.
  - `sync_err` pulses.
  - The beat is written to `out0` (strobe 0001) and `slot` becomes 1.
  - The state stays LOCKED.
  - No `frame_done` pulse is produced for the truncated frame.
- `frame_sync` with `in_valid` low is ignored in every state.
- While `in_valid` is low, the outputs hold their values, strobes are 0 and `slot` is unchanged.
- Reset asserted mid-frame clears all of the above immediately (asynchronously). The first beat after release must carry `frame_sync` to re-lock.
- `out_strobe` is one-hot or zero and never carries more than one bit.

## Timing
- Latency is 1 cycle. A beat sampled at edge k is visible on `outn` after edge k. `out_strobe`, `frame_done`, `sync_err` and the updated `slot`/`locked` are valid in that same cycle.
- Back-to-back beats are accepted on every cycle: full throughput, no back-pressure.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Reset release: the first edge with `rst_n` high may already accept a sync beat.

## Configuration
- `TDM_DEMUX_STRICT_SYNC_EN` defined: every slot-0 beat in LOCKED must carry `frame_sync`. For a slot-0 beat in LOCKED with `frame_sync` low:
  - `sync_err` pulses and the beat is discarded: no output write and no strobe.
  - The state moves to HUNT and `slot` returns to 0.
- Macro not defined: `frame_sync` is required only to lock. Slot-0 beats without it are accepted normally as slot 0, with no error.
- The resync behaviour for early `frame_sync` is identical in both builds.

## Test plan
- Reset, then beats A,B,C,D (`DATA_W`=1: 1,0,0,1) on consecutive cycles, with `frame_sync` only on A -> `out0`..`out3` = 1,0,0,1. Strobes are 0001, 0010, 0100, 1000 on successive cycles. `frame_done` pulses with the 1000 strobe, `locked` is 1, and `slot` wraps to 0.
- In HUNT, three valid beats without sync -> outputs stay 0, strobes stay 0, `locked` stays 0. The fourth beat, with sync -> `out0` updated and `locked` = 1 one cycle later.
- Locked, `slot`=2, valid beat with `frame_sync` -> `sync_err` pulses, `out0` takes the beat, `slot` = 1, no `frame_done`.
- Locked, `in_valid` low for 5 cycles mid-frame at `slot`=1, then resumes -> outputs hold throughout and the next beat lands in `out1`.
- Assert `rst_n` low at `slot`=2 -> all outputs are 0 immediately without a clock edge, `locked` is 0, and a non-sync beat after release is ignored.
- Locked, slot-0 beat without sync:
  - With `TDM_DEMUX_STRICT_SYNC_EN` -> `sync_err` pulses, `out0` is unchanged, `locked` drops to 0.
  - Without it -> `out0` is updated and no error.
